mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the data-memory word-address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of ACCESS cycles spent waiting for mem_ack.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 in_valid  input  1  X/M latch holds a valid instruction.
REQ-006 in_ins  input  32  instruction from X/M latch; opcode is [31:27], lw=01000, sw=00111.
REQ-007 in_o  input  32  ALU result; this is the word address for lw/sw.
REQ-008 in_b  input  32  store data.
REQ-009 in_ovf  input  1  ALU overflow flag.
REQ-010 stall  output  1  SHALL hold the upstream PC and latches while high.
REQ-011 out_valid, out_ins[32], out_o[32], out_d[32], out_ovf[1], out_err[1]  outputs  SHALL drive the M/W latch inputs.
REQ-012 mem_req, mem_we  outputs  1 each; mem_addr  output  ADDR_W; mem_wdata  output  32: request to data memory.
REQ-013 mem_rdata  input  32; mem_ack  input  1: response from data memory.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS and DONE, with a timeout counter of width clog2(TIMEOUT+1).
REQ-015 memop SHALL be defined as in_valid & (opcode==lw | opcode==sw) & !in_ovf.
REQ-016 IDLE, non-memop: outputs SHALL pass through combinationally (out_valid=in_valid, out_*=in_*, out_err=0, stall=0); state SHALL stay IDLE.
REQ-017 IDLE, memop: stall SHALL be 1 combinationally, and the unit SHALL capture in_ins, in_o, in_b and opcode.
REQ-018 From IDLE, a memop with in_o[31:ADDR_W]==0 SHALL go to ACCESS.
REQ-019 From IDLE, a memop with in_o[31:ADDR_W]!=0 SHALL go to DONE with err=1, and no request SHALL be issued.
REQ-020 ACCESS: mem_req=1, mem_we=(captured op==sw), mem_addr=captured in_o[ADDR_W-1:0], mem_wdata=captured in_b; stall SHALL be 1.
REQ-021 ACCESS: mem_req and its address, we and data SHALL stay stable until mem_ack is sampled high.
REQ-022 ACCESS, mem_ack=1: the unit SHALL capture mem_rdata (lw only) and go to DONE with err=0; the counter SHALL clear.
REQ-023 ACCESS, mem_ack=0: the counter SHALL increment.
REQ-024 ACCESS: when the counter equals TIMEOUT-1 and mem_ack=0, the unit SHALL go to DONE with err=1 and captured data=0.
REQ-025 If mem_ack and the timeout occur in the same cycle, mem_ack SHALL win.
REQ-026 DONE: stall=0; out_valid=1 for exactly one cycle; out_ins and out_o SHALL be the captured values; out_ovf=0; out_err=err.
REQ-027 DONE: out_d SHALL be the read data for lw and the captured store data for sw; next state SHALL be IDLE.
REQ-028 DONE: in_* SHALL be ignored, so the still-latched instruction is not re-issued.
REQ-029 mem_ack SHALL be ignored in IDLE and DONE.
REQ-030 lw/sw with in_ovf=1 SHALL pass through as in REQ-016, with out_ovf=1, no memory access and no stall.
REQ-031 Latency SHALL be 0 extra cycles for non-memory instructions.
REQ-032 A memory op whose ack arrives k cycles after mem_req rises SHALL cost k+2 cycles, stall high for k+1 of them.

Reset
REQ-033 reset=0 SHALL immediately force state=IDLE, counter=0 and all captured registers=0.
REQ-034 reset=0 SHALL immediately force mem_req=0, mem_we=0 and err=0; the combinational outputs then follow REQ-016.
REQ-035 Reset asserted during ACCESS SHALL drop mem_req within the same cycle, and no DONE pulse SHALL follow.
REQ-036 Operation SHALL resume on the first rising clk edge after reset returns high.

Verification
REQ-037 add (opcode 00000), in_o=0x5, in_valid=1 -> same cycle: out_valid=1, out_o=0x5, stall=0, mem_req never rises.
REQ-038 sw, in_o=0x10, in_b=0xDEADBEEF, ack 2 cycles after req -> mem_req=1, mem_we=1, mem_addr=0x010, wdata=0xDEADBEEF; stall high 3 cycles; one DONE pulse with out_d=0xDEADBEEF, out_err=0.
REQ-039 lw, in_o=0xFFF, ack with rdata=0x12345678 on the first ACCESS cycle -> mem_we=0; DONE: out_d=0x12345678, out_o=0xFFF.
REQ-040 lw, in_o=0x1000 -> no mem_req; one stall cycle, then DONE with out_err=1.
REQ-041 TIMEOUT=4, lw, ack never asserted -> mem_req high 4 cycles, then DONE with out_err=1 and out_d=0.
REQ-042 TIMEOUT=4, ack on the 4th ACCESS cycle -> out_err=0, mem_rdata taken.
REQ-043 Reset pulsed low mid-ACCESS -> mem_req=0 asynchronously, no out_valid pulse; a following add passes through normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage between the X/M and M/W latches: non-memory instructions pass
// straight through, while lw/sw stall the pipe and perform one data-memory transaction.
module mem_access_unit #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_ins,
    input  logic [31:0]       in_o,
    input  logic [31:0]       in_b,
    input  logic              in_ovf,
    output logic              stall,
    output logic              out_valid,
    output logic [31:0]       out_ins,
    output logic [31:0]       out_o,
    output logic [31:0]       out_d,
    output logic              out_ovf,
    output logic              out_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]        OP_LW    = 5'b01000;
    localparam logic [4:0]        OP_SW    = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_ins;
    logic [31:0]        r_o;
    logic [31:0]        r_b;
    logic [31:0]        r_d;
    logic               r_is_sw;
    logic               r_err;
    logic               r_mem_req;
    logic               r_mem_we;

    logic [4:0]         w_opcode;
    logic               w_is_lw;
    logic               w_is_sw;
    logic               w_memop;
    logic               w_addr_oob;

    assign w_opcode   = in_ins[31:27];
    assign w_is_lw    = (w_opcode == OP_LW);
    assign w_is_sw    = (w_opcode == OP_SW);
    assign w_memop    = in_valid & (w_is_lw | w_is_sw) & ~in_ovf;
    // Any set bit above the word-address field means the access is out of range.
    assign w_addr_oob = |(in_o >> ADDR_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ins     <= '0;
            r_o       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_is_sw   <= 1'b0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop) begin
                        r_ins   <= in_ins;
                        r_o     <= in_o;
                        r_b     <= in_b;
                        r_is_sw <= w_is_sw;
                        r_d     <= '0;
                        r_cnt   <= '0;
                        if (w_addr_oob) begin
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_ACCESS;
                            r_err     <= 1'b0;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= w_is_sw;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (mem_ack) begin
                        if (!r_is_sw) begin
                            r_d <= mem_rdata;
                        end
                        r_state   <= S_DONE;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_DONE;
                        r_err     <= 1'b1;
                        r_d       <= '0;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        out_valid = in_valid;
        out_ins   = in_ins;
        out_o     = in_o;
        out_d     = in_b;
        out_ovf   = in_ovf;
        out_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    stall     = 1'b1;
                    out_valid = 1'b0;
                end
            end
            S_ACCESS: begin
                stall     = 1'b1;
                out_valid = 1'b0;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_ins   = r_ins;
                out_o     = r_o;
                out_d     = r_is_sw ? r_b : r_d;
                out_ovf   = 1'b0;
                out_err   = r_err;
            end
            default: ;
        endcase
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_o[ADDR_W-1:0];
    assign mem_wdata = r_b;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of pass-through vectors plus
// hand-written memory transactions, timeout and mid-access reset sequences.
module tb_mem_access_unit;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [31:0]       in_ins;
    logic [31:0]       in_o;
    logic [31:0]       in_b;
    logic              in_ovf;
    logic              stall;
    logic              out_valid;
    logic [31:0]       out_ins;
    logic [31:0]       out_o;
    logic [31:0]       out_d;
    logic              out_ovf;
    logic              out_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ins    (in_ins),
        .in_o      (in_o),
        .in_b      (in_b),
        .in_ovf    (in_ovf),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ins   (out_ins),
        .out_o     (out_o),
        .out_d     (out_d),
        .out_ovf   (out_ovf),
        .out_err   (out_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] ins;
        logic [31:0] o;
        logic [31:0] b;
        logic        ovf;
        logic        e_valid;
        logic        e_ovf;
    } vec_t;

    // Drives one memory op from IDLE, acks on ACCESS cycle ack_at (0 = never),
    // and retires the instruction from the latch once its DONE cycle is seen.
    task automatic run_mem(input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata,
                           output int stalls, output int reqs,
                           output logic [31:0] d, output logic err,
                           output logic [31:0] oo, output logic [31:0] oins,
                           output logic oovf);
        int  acc;
        logic done;
        acc    = 0;
        done   = 1'b0;
        stalls = 0;
        reqs   = 0;
        d      = '0;
        err    = 1'b0;
        oo     = '0;
        oins   = '0;
        oovf   = 1'b0;
        in_valid  = 1'b1;
        in_ins    = {op, 27'h00ABCDE};
        in_o      = addr;
        in_b      = wdata;
        in_ovf    = 1'b0;
        mem_rdata = rdata;
        mem_ack   = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                acc++;
                reqs++;
                chk("req_we",    {31'b0, mem_we}, {31'b0, op == 5'b00111});
                chk("req_addr",  {20'b0, mem_addr}, {20'b0, addr[ADDR_W-1:0]});
                chk("req_wdata", mem_wdata, wdata);
                mem_ack = (acc == ack_at);
            end
            if (stall) stalls++;
            if (out_valid) begin
                done = 1'b1;
                d    = out_d;
                err  = out_err;
                oo   = out_o;
                oins = out_ins;
                oovf = out_ovf;
                mem_ack  = 1'b1;
                in_valid = 1'b0;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("one_pulse", {31'b0, out_valid}, 32'd0);
    endtask

    vec_t vecs[6];
    int          st, rq;
    logic [31:0] rd, ro, ri;
    logic        re, rov;

    initial begin
        vecs[0] = '{1'b1, {5'b00000, 27'h0}, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, {5'b00000, 27'h1}, 32'hFFFF_FFFF, 32'h1111_2222, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, {5'b01000, 27'h2}, 32'h0000_0040, 32'h3333_4444, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, {5'b00111, 27'h3}, 32'h0000_2000, 32'h5555_6666, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, {5'b01000, 27'h4}, 32'h0000_0040, 32'h7777_8888, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, {5'b11111, 27'h5}, 32'h0000_0ABC, 32'h9999_AAAA, 1'b0, 1'b1, 1'b0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_ins    = '0;
        in_o      = '0;
        in_b      = '0;
        in_ovf    = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #2;
        chk("rst_req",   {31'b0, mem_req},   32'd0);
        chk("rst_we",    {31'b0, mem_we},    32'd0);
        chk("rst_stall", {31'b0, stall},     32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err",   {31'b0, out_err},   32'd0);
        #10 reset = 1'b1;
        tick();

        // Pass-through vectors; ack held high to show it is ignored in IDLE.
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].valid;
            in_ins   = vecs[i].ins;
            in_o     = vecs[i].o;
            in_b     = vecs[i].b;
            in_ovf   = vecs[i].ovf;
            #1;
            chk("pt_valid", {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            chk("pt_stall", {31'b0, stall},     32'd0);
            chk("pt_ins",   out_ins,            vecs[i].ins);
            chk("pt_o",     out_o,              vecs[i].o);
            chk("pt_d",     out_d,              vecs[i].b);
            chk("pt_ovf",   {31'b0, out_ovf},   {31'b0, vecs[i].e_ovf});
            chk("pt_err",   {31'b0, out_err},   32'd0);
            tick();
            chk("pt_noreq", {31'b0, mem_req},   32'd0);
        end
        mem_ack  = 1'b0;
        in_valid = 1'b0;
        tick();

        // sw, ack on the 2nd ACCESS cycle
        run_mem(5'b00111, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0BAD_0BAD, st, rq, rd, re, ro, ri, rov);
        chk("sw_stalls", 32'(st), 32'd3);
        chk("sw_reqs",   32'(rq), 32'd2);
        chk("sw_d",      rd, 32'hDEAD_BEEF);
        chk("sw_err",    {31'b0, re}, 32'd0);
        chk("sw_o",      ro, 32'h0000_0010);
        chk("sw_ins",    ri, {5'b00111, 27'h00ABCDE});
        chk("sw_ovf",    {31'b0, rov}, 32'd0);

        // lw at top of address space, ack on the first ACCESS cycle
        run_mem(5'b01000, 32'h0000_0FFF, 32'h0000_0001, 1, 32'h1234_5678, st, rq, rd, re, ro, ri, rov);
        chk("lw_stalls", 32'(st), 32'd2);
        chk("lw_reqs",   32'(rq), 32'd1);
        chk("lw_d",      rd, 32'h1234_5678);
        chk("lw_err",    {31'b0, re}, 32'd0);
        chk("lw_o",      ro, 32'h0000_0FFF);

        // lw just past the address space
        run_mem(5'b01000, 32'h0000_1000, 32'h0, 1, 32'hFFFF_FFFF, st, rq, rd, re, ro, ri, rov);
        chk("oob_stalls", 32'(st), 32'd1);
        chk("oob_reqs",   32'(rq), 32'd0);
        chk("oob_err",    {31'b0, re}, 32'd1);
        chk("oob_o",      ro, 32'h0000_1000);

        // lw, no ack ever
        run_mem(5'b01000, 32'h0000_0123, 32'h0, 0, 32'hA5A5_A5A5, st, rq, rd, re, ro, ri, rov);
        chk("to_stalls", 32'(st), 32'd5);
        chk("to_reqs",   32'(rq), 32'd4);
        chk("to_d",      rd, 32'h0);
        chk("to_err",    {31'b0, re}, 32'd1);

        // lw, ack in the final allowed ACCESS cycle
        run_mem(5'b01000, 32'h0000_0456, 32'h0, 4, 32'hCAFE_F00D, st, rq, rd, re, ro, ri, rov);
        chk("late_reqs", 32'(rq), 32'd4);
        chk("late_d",    rd, 32'hCAFE_F00D);
        chk("late_err",  {31'b0, re}, 32'd0);

        // Reset pulsed mid-ACCESS
        in_valid = 1'b1;
        in_ins   = {5'b01000, 27'h0};
        in_o     = 32'h0000_0020;
        in_b     = 32'h0;
        in_ovf   = 1'b0;
        tick();
        chk("mid_req_up", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_req_drop", {31'b0, mem_req}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                if (out_valid || mem_req) pulses++;
                tick();
            end
            chk("mid_no_pulse", 32'(pulses), 32'd0);
        end
        in_valid = 1'b1;
        in_ins   = {5'b00000, 27'h0};
        in_o     = 32'h0000_0005;
        in_b     = 32'h0;
        #1;
        chk("post_add_valid", {31'b0, out_valid}, 32'd1);
        chk("post_add_o",     out_o, 32'h0000_0005);
        chk("post_add_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("post_add_noreq", {31'b0, mem_req}, 32'd0);
        in_valid = 1'b0;
        tick();

        run_mem(5'b00111, 32'h0000_0ABC, 32'h1357_9BDF, 1, 32'h0, st, rq, rd, re, ro, ri, rov);
        chk("post_sw_d",   rd, 32'h1357_9BDF);
        chk("post_sw_err", {31'b0, re}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
